pwm_fade_ramp: RTL and testbench

//  Upstream stage of the PWM driver: accepts brightness targets over a valid/ready handshake.

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/pwm_fade_gamma.sv | 36 +++
 rtl/pwm_fade_ramp.sv | 103 ++++++++++
 tb/tb_pwm_fade_ramp.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and step/clamp arithmetic for the PWM fade ramp.
// Latency: n/a (package). Backpressure: n/a.
// Build option PWM_FADE_GAMMA_EN selects the square-law duty curve in pwm_fade_gamma.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    localparam int PWM_BITS_DEFAULT = 12;

    // One ramp step toward tgt, saturating at tgt. In the down direction cur > tgt holds,
    // so cur - tgt cannot borrow.
    function automatic logic [31:0] ramp_clamp(input logic [31:0] cur,
                                               input logic [31:0] step,
                                               input logic [31:0] tgt,
                                               input logic        up);
        logic [32:0] sum;
        logic [31:0] res;
        sum = {1'b0, cur} + {1'b0, step};
        if (up)
            res = (sum >= {1'b0, tgt}) ? tgt : sum[31:0];
        else
            res = (step >= cur - tgt) ? tgt : cur - step;
        return res;
    endfunction

endpackage

// File: rtl/pwm_fade_gamma.sv
// Maps the ramp value onto the compare curve: square-law with PWM_FADE_GAMMA_EN, else linear.
// Latency: 1 cycle (registered pipe). Backpressure: none, updates every cycle.
// Build option PWM_FADE_GAMMA_EN selects the multiplier path.
module pwm_fade_gamma
    import pwm_pkg::*;
#(
    parameter int pwm_bits = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [pwm_bits-1:0] cur,
    output logic [pwm_bits-1:0] pipe
);

    logic [pwm_bits-1:0] curve;

`ifdef PWM_FADE_GAMMA_EN
    logic [2*pwm_bits-1:0] cur_w;
    logic [2*pwm_bits-1:0] prod;

    // cur+1 is formed at double width so all-ones maps exactly onto all-ones.
    assign cur_w = {{pwm_bits{1'b0}}, cur};
    assign prod  = cur_w * (cur_w + (2*pwm_bits)'(1));
    assign curve = pwm_bits'(prod >> pwm_bits);
`else
    assign curve = cur;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            pipe <= '0;
        else
            pipe <= curve;
    end

endmodule

// File: rtl/pwm_fade_ramp.sv
// Ramps duty toward accepted targets at a prescaled tick; duty_out reloads only at period_end.
// Latency: cur -> pipe 1 clk, pipe -> duty_out at next period_end; done 1 clk after final tick.
// Backpressure: tgt_ready = !busy; requests during a ramp are ignored. Option PWM_FADE_GAMMA_EN.
module pwm_fade_ramp
    import pwm_pkg::*;
#(
    parameter int pwm_bits     = PWM_BITS_DEFAULT,
    parameter int step_bits    = 4,
    parameter int prescale_div = 256
) (
    input  logic                 clk_inc,
    input  logic                 rst,
    input  logic                 tgt_valid,
    output logic                 tgt_ready,
    input  logic [pwm_bits-1:0]  tgt_duty,
    input  logic [step_bits-1:0] tgt_step,
    input  logic                 period_end,
    output logic [pwm_bits-1:0]  duty_out,
    output logic                 busy,
    output logic                 done
);

    localparam int PS_W = (prescale_div > 1) ? $clog2(prescale_div) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(prescale_div - 1);

    state_t               state;
    logic [pwm_bits-1:0]  cur;
    logic [pwm_bits-1:0]  target;
    logic [step_bits-1:0] step;
    logic [PS_W-1:0]      ps;
    logic [pwm_bits-1:0]  nxt;
    logic [pwm_bits-1:0]  pipe;

    assign tgt_ready = !busy;
    assign nxt = pwm_bits'(ramp_clamp(32'(cur), 32'(step), 32'(target), state == ST_UP));

    always_ff @(posedge clk_inc) begin
        if (rst) begin
            state  <= ST_IDLE;
            cur    <= '0;
            target <= '0;
            step   <= '0;
            ps     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tgt_valid) begin
                        target <= tgt_duty;
                        step   <= (tgt_step == '0) ? step_bits'(1) : tgt_step;
                        ps     <= '0;
                        if (tgt_duty > cur) begin
                            state <= ST_UP;
                            busy  <= 1'b1;
                        end else if (tgt_duty < cur) begin
                            state <= ST_DOWN;
                            busy  <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_UP, ST_DOWN: begin
                    if (ps == PS_LAST) begin
                        ps  <= '0;
                        cur <= nxt;
                        if (nxt == target) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        ps <= ps + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    pwm_fade_gamma #(
        .pwm_bits(pwm_bits)
    ) u_gamma (
        .clk (clk_inc),
        .rst (rst),
        .cur (cur),
        .pipe(pipe)
    );

    // Shadow register: the comparator only ever sees whole-period duty values.
    always_ff @(posedge clk_inc) begin
        if (rst)
            duty_out <= '0;
        else if (period_end)
            duty_out <= pipe;
    end

endmodule

// File: tb/tb_pwm_fade_ramp.sv
// Scoreboard bench for pwm_fade_ramp: a closed-form reference model predicts every cycle's outputs.
module tb_pwm_fade_ramp;

    localparam int W = 12;
    localparam int SB = 4;
    localparam int P = 4;
    localparam int MAXV = (1 << W) - 1;

    logic          clk_inc = 1'b0;
    logic          rst = 1'b1;
    logic          tgt_valid = 1'b0;
    logic          tgt_ready;
    logic [W-1:0]  tgt_duty = '0;
    logic [SB-1:0] tgt_step = '0;
    logic          period_end = 1'b0;
    logic [W-1:0]  duty_out;
    logic          busy;
    logic          done;

    pwm_fade_ramp #(.pwm_bits(W), .step_bits(SB), .prescale_div(P)) dut (
        .clk_inc   (clk_inc),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_duty  (tgt_duty),
        .tgt_step  (tgt_step),
        .period_end(period_end),
        .duty_out  (duty_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_inc = ~clk_inc;

    typedef struct {
        int duty;
        bit busy;
        bit ready;
        bit done;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;
    bit   pe_hold = 1'b0;

    // Reference model state: ramp described by start value, target, step and elapsed edges.
    int m_cur = 0, m_pipe = 0, m_duty = 0;
    int m_c0 = 0, m_tgt = 0, m_step = 1, m_el = 0;
    bit m_act = 1'b0, m_up = 1'b0, m_done = 1'b0;

    function automatic int f_ref(input int c);
`ifdef PWM_FADE_GAMMA_EN
        longint p;
        p = longint'(c) * longint'(c + 1);
        return int'(p >> W);
`else
        return c;
`endif
    endfunction

    always @(posedge clk_inc) begin
        exp_t e;
        int ticks, nc;
        edge_n++;
        if (rst) begin
            m_cur = 0; m_pipe = 0; m_duty = 0; m_act = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (period_end) m_duty = m_pipe;
            m_pipe = f_ref(m_cur);
            if (m_act) begin
                m_el++;
                if (m_el % P == 0) begin
                    ticks = m_el / P;
                    if (m_up) nc = (m_c0 + ticks * m_step > m_tgt) ? m_tgt : m_c0 + ticks * m_step;
                    else      nc = (m_c0 - ticks * m_step < m_tgt) ? m_tgt : m_c0 - ticks * m_step;
                    m_cur = nc;
                    if (nc == m_tgt) begin
                        m_act = 0;
                        m_done = 1;
                    end
                end
            end else if (tgt_valid) begin
                m_c0 = m_cur;
                m_tgt = int'(tgt_duty);
                m_step = (tgt_step == 0) ? 1 : int'(tgt_step);
                m_el = 0;
                if (m_tgt == m_c0) m_done = 1;
                else begin
                    m_act = 1;
                    m_up = (m_tgt > m_c0);
                end
            end
        end
        e.duty = m_duty; e.busy = m_act; e.ready = !m_act; e.done = m_done;
        q.push_back(e);
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_n, got, exp);
        end
    endtask

    // Monitor: pops one expectation per presented output cycle.
    always @(posedge clk_inc) begin
        exp_t e;
        #1;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = q.pop_front();
            chk("duty_out", int'(duty_out), e.duty);
            chk("busy", int'(busy), int'(e.busy));
            chk("tgt_ready", int'(tgt_ready), int'(e.ready));
            chk("done", int'(done), int'(e.done));
        end
    end

    // PWM period pulses every 8 clocks unless held off.
    initial begin
        forever begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk_inc);
                period_end = (i == 7) && !pe_hold;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_inc);
    endtask

    task automatic req(input int t, input int s);
        int k;
        k = 0;
        @(negedge clk_inc);
        while (!tgt_ready && k < 20000) begin
            @(negedge clk_inc);
            k++;
        end
        if (k >= 20000) chk("ready_timeout", 0, 1);
        tgt_valid = 1'b1;
        tgt_duty = W'(t);
        tgt_step = SB'(s);
        @(negedge clk_inc);
        tgt_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit junk);
        int k;
        k = 0;
        while (busy && k < 20000) begin
            tgt_valid = junk && busy;
            tgt_duty = W'($urandom_range(0, MAXV));
            tgt_step = SB'($urandom_range(0, 15));
            @(negedge clk_inc);
            k++;
        end
        tgt_valid = 1'b0;
        if (k >= 20000) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog edge=%0d got=running expected=finished", edge_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d, t;
        tick(3);
        rst = 1'b0;
        tick(2);
        req(16, 4);      wait_idle(0); tick(12);
        req(4090, 15);   wait_idle(0); tick(10);
        req(4095, 15);   wait_idle(0); tick(10);
        req(4000, 15);   wait_idle(0);
        req(4002, 0);    wait_idle(0); tick(10);
        req(5, 15);      wait_idle(0);
        req(0, 15);      wait_idle(0); tick(10);
        req(20, 15);     wait_idle(0);
        req(18, 15);     wait_idle(0); tick(10);
        req(200, 3);     wait_idle(1); tick(4);
        req(200, 7);     tick(12);
        req(2048, 15);   wait_idle(0); tick(20);
        req(4095, 15);   wait_idle(0); tick(20);
        req(0, 15);      wait_idle(0); tick(20);
        pe_hold = 1'b1;
        req(1000, 15);   wait_idle(0); tick(20);
        pe_hold = 1'b0;
        tick(20);
        req(3000, 5);    tick(30);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(10);
        for (int i = 0; i < 40; i++) begin
            d = $urandom_range(0, 150);
            t = $urandom_range(0, 1) ? m_cur + d : m_cur - d;
            if (t < 0) t = 0;
            if (t > MAXV) t = MAXV;
            pe_hold = ($urandom_range(0, 5) == 0);
            req(t, $urandom_range(0, 15));
            wait_idle($urandom_range(0, 1) == 1);
            tick($urandom_range(0, 10));
        end
        pe_hold = 1'b0;
        tick(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
